// File: rtl/regwrite_trace_buffer_pkg.sv
// regwrite_trace_buffer_pkg: shared widths, record layout and FSM encoding for the trace buffer
package regwrite_trace_buffer_pkg;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int REG_AW_DEF      = 5;
  localparam int CYCLE_WIDTH_DEF = 16;
  localparam int DEPTH_DEF       = 64;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;
  function automatic int rec_width(int cw, int aw, int dw);
    return cw + aw + dw;
  endfunction
endpackage

// File: rtl/regwrite_trace_buffer_fifo.sv
// regwrite_trace_buffer_fifo: FWFT sync FIFO with flush and optional overwrite of the oldest entry
module regwrite_trace_buffer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic             overwrite_oldest,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W:0]   count,
  output logic             lost
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic full, empty, do_pop, do_push, adv;
  always_comb begin
    full = count == (PTR_W+1)'(DEPTH);
    empty = count == '0;
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop || overwrite_oldest);
    // head also moves when a full buffer overwrites its oldest entry
    adv = do_pop || (do_push && full);
    lost = push && full && !do_pop;
    rdata = empty ? '0 : mem[rptr];
  end
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (adv) rptr <= rptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(adv);
    end
  end
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/regwrite_trace_buffer.sv
// regwrite_trace_buffer: timestamps nonzero-register writebacks inside an armed capture window
module regwrite_trace_buffer
  import regwrite_trace_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int CYCLE_WIDTH = CYCLE_WIDTH_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int PTR_W       = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   mode_wrap,
  input  logic [CYCLE_WIDTH-1:0] start_cycle,
  input  logic [CYCLE_WIDTH-1:0] num_cycles,
  input  logic                   mon_we,
  input  logic [REG_AW-1:0]      mon_rd,
  input  logic [DATA_WIDTH-1:0]  mon_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CYCLE_WIDTH-1:0] out_cycle,
  output logic [REG_AW-1:0]      out_rd,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [PTR_W:0]         count,
  output logic                   overflow,
  output logic                   done
);
  localparam int RW = rec_width(CYCLE_WIDTH, REG_AW, DATA_WIDTH);
  state_t state;
  logic [CYCLE_WIDTH-1:0] cycle_cnt, win_cnt;
  logic [RW-1:0] rdata;
  logic in_win, last, push, lost;
  always_comb begin
    // the start cycle itself is captured while the FSM still reads WAIT
    in_win = state == CAPTURE || (state == WAIT && cycle_cnt == start_cycle);
    last = in_win && num_cycles != '0 && win_cnt + 1'b1 == num_cycles;
    push = in_win && mon_we && mon_rd != '0 && !arm;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cycle_cnt <= '0;
      win_cnt <= '0;
      overflow <= 1'b0;
      done <= 1'b0;
    end else if (arm) begin
      state <= WAIT;
      cycle_cnt <= '0;
      win_cnt <= '0;
      overflow <= 1'b0;
      done <= 1'b0;
    end else begin
      if (state != IDLE) cycle_cnt <= cycle_cnt + 1'b1;
      if (in_win) begin
        win_cnt <= win_cnt + 1'b1;
        state <= last ? DONE : CAPTURE;
        done <= last;
      end
      if (lost) overflow <= 1'b1;
    end
  end
  regwrite_trace_buffer_fifo #(.WIDTH(RW), .DEPTH(DEPTH), .PTR_W(PTR_W)) fifo (
    .clock(clock),
    .reset(reset),
    .flush(arm),
    .push(push),
    .pop(out_ready),
    .overwrite_oldest(mode_wrap),
    .wdata({cycle_cnt, mon_rd, mon_data}),
    .rdata(rdata),
    .count(count),
    .lost(lost)
  );
  assign out_valid = count != '0;
  assign {out_cycle, out_rd, out_data} = rdata;
endmodule

// File: tb/tb_regwrite_trace_buffer.sv
// tb_regwrite_trace_buffer: directed tables, corner sequences and random traffic against a queue model
module tb_regwrite_trace_buffer;
  localparam int DEPTH = 4;
  logic clock = 0, reset = 1, arm = 0, mode_wrap = 0, mon_we = 0, out_ready = 0;
  logic [15:0] start_cycle = 0, num_cycles = 0, out_cycle;
  logic [4:0] mon_rd = 0, out_rd;
  logic [31:0] mon_data = 0, out_data;
  logic out_valid, overflow, done;
  logic [2:0] count;
  int n_checks = 0, n_fail = 0;

  regwrite_trace_buffer #(.DATA_WIDTH(32), .REG_AW(5), .CYCLE_WIDTH(16), .DEPTH(DEPTH), .PTR_W(2)) dut (
    .clock(clock), .reset(reset), .arm(arm), .mode_wrap(mode_wrap), .start_cycle(start_cycle),
    .num_cycles(num_cycles), .mon_we(mon_we), .mon_rd(mon_rd), .mon_data(mon_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_cycle(out_cycle), .out_rd(out_rd),
    .out_data(out_data), .count(count), .overflow(overflow), .done(done)
  );
  always #5 clock = ~clock;

  typedef struct {logic [15:0] c; logic [4:0] r; logic [31:0] d;} rec_t;
  rec_t mq[$];
  int ms = 0, mwin = 0;
  logic [15:0] mcyc = 0;
  logic movf = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    rec_t h;
    h = mq.size() > 0 ? mq[0] : '{c: 16'd0, r: 5'd0, d: 32'd0};
    chk("m_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("m_count", 64'(count), 64'(mq.size()));
    chk("m_overflow", 64'(overflow), 64'(movf));
    chk("m_done", 64'(done), 64'(ms == 3));
    chk("m_cycle", 64'(out_cycle), 64'(h.c));
    chk("m_rd", 64'(out_rd), 64'(h.r));
    chk("m_data", 64'(out_data), 64'(h.d));
  endtask

  task automatic model_step();
    bit cap;
    rec_t r;
    if (reset || arm) begin
      ms = reset ? 0 : 1;
      mcyc = 0;
      mwin = 0;
      movf = 0;
      mq.delete();
    end else begin
      cap = ms == 2 || (ms == 1 && mcyc == start_cycle);
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (cap && mon_we && mon_rd != 0) begin
        r = '{c: mcyc, r: mon_rd, d: mon_data};
        if (mq.size() < DEPTH) mq.push_back(r);
        else begin
          movf = 1;
          if (mode_wrap) begin
            void'(mq.pop_front());
            mq.push_back(r);
          end
        end
      end
      if (ms != 0) mcyc++;
      if (cap) begin
        mwin++;
        ms = (num_cycles != 0 && mwin == int'(num_cycles)) ? 3 : 2;
      end
    end
  endtask

  task automatic tick();
    check_model();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_arm(input logic [15:0] s, input logic [15:0] n, input logic w);
    start_cycle = s;
    num_cycles = n;
    mode_wrap = w;
    arm = 1;
    tick();
    arm = 0;
  endtask

  task automatic drain_expect(input string nm, input int exp0, input int exp1, input int exp2, input int exp3);
    int got[$];
    int e[4];
    e = '{exp0, exp1, exp2, exp3};
    mon_we = 0;
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) got.push_back(int'(out_rd));
      tick();
    end
    out_ready = 0;
    chk({nm, "_n"}, 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk({nm, "_rd"}, 64'(got[i]), 64'(e[i]));
  endtask

  task automatic writes(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      mon_we = 1;
      mon_rd = 5'(base + i);
      mon_data = 32'(base + i) * 32'h11;
      tick();
    end
    mon_we = 0;
  endtask

  typedef struct {
    logic we; logic [4:0] rd; logic [31:0] data; logic ready;
    logic ev; int ecnt; logic [15:0] ecyc; logic [4:0] erd; logic [31:0] edata;
  } vec_t;
  vec_t tv[11];

  initial begin
    int got[$];
    tv[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[3]  = '{1, 5, 7, 0, 0, 0, 0, 0, 0};
    tv[4]  = '{1, 0, 9, 0, 1, 1, 3, 5, 7};
    tv[5]  = '{0, 0, 0, 0, 1, 1, 3, 5, 7};
    tv[6]  = '{1, 31, 32'hFFFFFFFF, 0, 1, 1, 3, 5, 7};
    tv[7]  = '{0, 0, 0, 0, 1, 2, 3, 5, 7};
    tv[8]  = '{0, 0, 0, 1, 1, 2, 3, 5, 7};
    tv[9]  = '{0, 0, 0, 1, 1, 1, 6, 31, 32'hFFFFFFFF};
    tv[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    tick();
    tick();
    reset = 0;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_done", 64'(done), 64'd0);

    // basic capture, r0 filtered, FWFT latency and draining
    do_arm(0, 0, 0);
    foreach (tv[i]) begin
      mon_we = tv[i].we;
      mon_rd = tv[i].rd;
      mon_data = tv[i].data;
      out_ready = tv[i].ready;
      chk("t1_valid", 64'(out_valid), 64'(tv[i].ev));
      chk("t1_count", 64'(count), 64'(tv[i].ecnt));
      chk("t1_cycle", 64'(out_cycle), 64'(tv[i].ecyc));
      chk("t1_rd", 64'(out_rd), 64'(tv[i].erd));
      chk("t1_data", 64'(out_data), 64'(tv[i].edata));
      tick();
    end

    // bounded window starting at cycle 10
    do_arm(10, 5, 0);
    out_ready = 1;
    for (int c = 0; c < 20; c++) begin
      mon_we = c >= 8 && c <= 16;
      mon_rd = 1;
      mon_data = 32'(c);
      if (out_valid) got.push_back(int'(out_cycle));
      if (c == 14) chk("t2_done_c14", 64'(done), 64'd0);
      if (c == 15) chk("t2_done_c15", 64'(done), 64'd1);
      tick();
    end
    chk("t2_done_end", 64'(done), 64'd1);
    chk("t2_n", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("t2_cycle", 64'(got[i]), 64'(10 + i));
    out_ready = 0;

    // full buffer, drop mode
    do_arm(0, 0, 0);
    writes(6, 1);
    tick();
    chk("t3_count", 64'(count), 64'd4);
    chk("t3_overflow", 64'(overflow), 64'd1);
    drain_expect("t3", 1, 2, 3, 4);

    // full buffer, wrap mode
    do_arm(0, 0, 1);
    writes(6, 1);
    tick();
    chk("t4_count", 64'(count), 64'd4);
    chk("t4_overflow", 64'(overflow), 64'd1);
    drain_expect("t4", 3, 4, 5, 6);

    // pop and push together while full
    do_arm(0, 0, 0);
    writes(4, 1);
    tick();
    out_ready = 1;
    mon_we = 1;
    mon_rd = 9;
    mon_data = 32'h99;
    tick();
    out_ready = 0;
    mon_we = 0;
    chk("t5_count", 64'(count), 64'd4);
    chk("t5_overflow", 64'(overflow), 64'd0);
    drain_expect("t5", 2, 3, 4, 9);

    // reset mid-capture
    do_arm(0, 0, 0);
    writes(3, 1);
    chk("t6_count_pre", 64'(count), 64'd3);
    reset = 1;
    mon_we = 1;
    mon_rd = 7;
    tick();
    reset = 0;
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_idle_count", 64'(count), 64'd0);
    mon_we = 0;

    // random traffic against the queue model
    do_arm(16'($urandom_range(0, 12)), 16'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 599) == 0;
      arm = $urandom_range(0, 79) == 0;
      if (arm) begin
        start_cycle = 16'($urandom_range(0, 12));
        num_cycles = 16'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 29) == 0) mode_wrap = ~mode_wrap;
      out_ready = (i / 40) % 2 == 0 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      mon_we = 1'($urandom_range(0, 1));
      mon_rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
      mon_data = $urandom;
      tick();
    end
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
